branch_hazard_ctrl: RTL and testbench

Stall and flush sequencer for branches resolved in the ID stage of the 5-stage MIPS pipeline. It detects when an ID-stage branch needs a load result that operand forwarding cannot yet supply. It then freezes PC and IF/ID for a fixed number of cycles and inserts bubbles into ID/EX. Once the branch resolves taken, it squashes the wrong-path fetch. Saturating counters track stall cycles and flushes for performance debug.

---
 rtl/branch_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: stall/flush sequencer for branches resolved in ID.
// Detects branch operands that depend on a load still in EX or MEM, freezes
// PC and IF/ID while bubbles go into ID/EX, and squashes the wrong-path
// fetch when the branch resolves taken. Saturating counters record stall
// cycles and flushes for performance debug.
module branch_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_is_branch,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             branch_taken,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       ex_mem_rd,
   input  logic             id_ex_regwrite,
   input  logic             ex_mem_regwrite,
   input  logic             id_ex_memread,
   input  logic             ex_mem_memread,
   input  logic             mem_stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             stalling,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [1:0]       remain_q, remain_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic ex_match, mem_match;
   logic load_ex, load_mem;

   // Hazard detection: only loads stall, and register $0 never matches.
   always_comb begin
      ex_match  = (id_ex_rd != 5'd0) && ((id_ex_rd == id_rs) || (id_ex_rd == id_rt));
      mem_match = (ex_mem_rd != 5'd0) && ((ex_mem_rd == id_rs) || (ex_mem_rd == id_rt));
      load_ex   = id_is_branch && id_ex_regwrite && id_ex_memread && ex_match;
      load_mem  = id_is_branch && ex_mem_regwrite && ex_mem_memread && mem_match;
   end

   // Next-state and Mealy control outputs; mem_stall freezes everything.
   always_comb begin
      state_d      = state_q;
      remain_d     = remain_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (!rst_n) begin
         state_d  = RUN;
         remain_d = 2'd0;
      end else if (mem_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (load_ex) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  remain_d     = 2'd1;
                  state_d      = STALL;
               end else if (load_mem) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end else if (id_is_branch && branch_taken) begin
                  if_id_flush = 1'b1;
               end
            end
            STALL: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               if (remain_q <= 2'd1) begin
                  remain_d = 2'd0;
                  state_d  = RUN;
               end else begin
                  remain_d = remain_q - 2'd1;
               end
            end
            default: begin
               state_d  = RUN;
               remain_d = 2'd0;
            end
         endcase
      end
   end

   // Saturating performance counters driven by the control outputs.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (id_ex_bubble && (stall_cycles_q != CNT_MAX))
         stall_cycles_d = stall_cycles_q + CNT_ONE;
      if (if_id_flush && (flush_count_q != CNT_MAX))
         flush_count_d = flush_count_q + CNT_ONE;
   end

   // State, stall counter and performance counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= RUN;
         remain_q       <= 2'd0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         remain_q       <= remain_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   // Registered status: stalling reflects the STALL state, forced low in reset.
   always_comb begin
      stalling     = rst_n && (state_q == STALL);
      stall_cycles = stall_cycles_q;
      flush_count  = flush_count_q;
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the stall/flush rules.
module tb_branch_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_is_branch, branch_taken;
   logic [4:0]       id_rs, id_rt, id_ex_rd, ex_mem_rd;
   logic             id_ex_regwrite, ex_mem_regwrite, id_ex_memread, ex_mem_memread;
   logic             mem_stall;
   logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, stalling;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int vectors = 0;
   int miscompares = 0;

   // model state
   int m_left = 0;
   int m_stall_cnt = 0;
   int m_flush_cnt = 0;
   bit model_ok = 0;

   // values sampled in the most recent cycle
   logic s_pc, s_ifid, s_bub, s_fl, s_stalling;
   logic [CNT_W-1:0] s_sc, s_fc;

   branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_is_branch(id_is_branch), .id_rs(id_rs), .id_rt(id_rt),
      .branch_taken(branch_taken),
      .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
      .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite),
      .id_ex_memread(id_ex_memread), .ex_mem_memread(ex_mem_memread),
      .mem_stall(mem_stall),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
      .stalling(stalling), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      id_is_branch = 0; branch_taken = 0; id_rs = 0; id_rt = 0;
      id_ex_rd = 0; ex_mem_rd = 0; id_ex_regwrite = 0; ex_mem_regwrite = 0;
      id_ex_memread = 0; ex_mem_memread = 0; mem_stall = 0;
   endtask

   // One clock cycle: inputs already applied after a falling edge. Compare
   // the DUT with the model, advance the model, then wait for the next fall.
   task automatic cyc();
      bit e_pc, e_ifid, e_bub, e_fl, e_stalling, lex, lmem;
      int nl;
      #1;
      e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0;
      e_stalling = rst_n && (m_left > 0);
      nl = m_left;
      lex  = id_is_branch && id_ex_regwrite && id_ex_memread && id_ex_rd != 0 &&
             (id_ex_rd == id_rs || id_ex_rd == id_rt);
      lmem = id_is_branch && ex_mem_regwrite && ex_mem_memread && ex_mem_rd != 0 &&
             (ex_mem_rd == id_rs || ex_mem_rd == id_rt);
      if (!rst_n) begin
         nl = 0;
      end else if (mem_stall) begin
         e_pc = 0; e_ifid = 0;
      end else if (m_left > 0) begin
         e_pc = 0; e_ifid = 0; e_bub = 1; nl = m_left - 1;
      end else if (lex) begin
         e_pc = 0; e_ifid = 0; e_bub = 1; nl = 1;
      end else if (lmem) begin
         e_pc = 0; e_ifid = 0; e_bub = 1;
      end else if (id_is_branch && branch_taken) begin
         e_fl = 1;
      end
      s_pc = pc_write; s_ifid = if_id_write; s_bub = id_ex_bubble;
      s_fl = if_id_flush; s_stalling = stalling; s_sc = stall_cycles; s_fc = flush_count;
      if (model_ok) begin
         chk("pc_write", 32'(pc_write), 32'(e_pc));
         chk("if_id_write", 32'(if_id_write), 32'(e_ifid));
         chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
         chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
         chk("stalling", 32'(stalling), 32'(e_stalling));
         chk("stall_cycles", 32'(stall_cycles), 32'(m_stall_cnt));
         chk("flush_count", 32'(flush_count), 32'(m_flush_cnt));
      end
      if (!rst_n) begin
         m_stall_cnt = 0; m_flush_cnt = 0; model_ok = 1;
      end else begin
         if (e_bub && m_stall_cnt < CMAX) m_stall_cnt++;
         if (e_fl && m_flush_cnt < CMAX) m_flush_cnt++;
      end
      m_left = nl;
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      cyc();
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      @(negedge clk);
      cyc();
      cyc();
      rst_n = 1;

      // idle after reset
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("idle_pc", 32'(s_pc), 1);
         chk("idle_bub", 32'(s_bub), 0);
      end
      chk("idle_stall_cnt", 32'(stall_cycles), 0);
      chk("idle_flush_cnt", 32'(flush_count), 0);

      // lw $5 in EX, beq $5,$6 in ID
      do_reset();
      id_is_branch = 1; id_rs = 5; id_rt = 6; branch_taken = 1;
      id_ex_rd = 5; id_ex_regwrite = 1; id_ex_memread = 1;
      cyc();
      chk("lex_c1_pc", 32'(s_pc), 0);
      chk("lex_c1_bub", 32'(s_bub), 1);
      chk("lex_c1_stalling", 32'(s_stalling), 0);
      cyc();
      chk("lex_c2_pc", 32'(s_pc), 0);
      chk("lex_c2_stalling", 32'(s_stalling), 1);
      id_ex_rd = 0; id_ex_regwrite = 0; id_ex_memread = 0;
      cyc();
      chk("lex_c3_flush", 32'(s_fl), 1);
      chk("lex_c3_pc", 32'(s_pc), 1);
      idle_inputs();
      cyc();
      chk("lex_stall_cnt", 32'(s_sc), 2);
      chk("lex_flush_cnt", 32'(s_fc), 1);

      // lw $7 in MEM, bne $0,$7 in ID
      do_reset();
      id_is_branch = 1; id_rs = 0; id_rt = 7;
      ex_mem_rd = 7; ex_mem_regwrite = 1; ex_mem_memread = 1;
      cyc();
      chk("lmem_bub", 32'(s_bub), 1);
      ex_mem_rd = 0; ex_mem_regwrite = 0; ex_mem_memread = 0;
      cyc();
      chk("lmem_after_bub", 32'(s_bub), 0);
      chk("lmem_stall_cnt", 32'(stall_cycles), 1);
      // same with rd=$0: no stall
      ex_mem_rd = 0; ex_mem_regwrite = 1; ex_mem_memread = 1; id_rt = 0;
      cyc();
      chk("r0_no_bub", 32'(s_bub), 0);

      // add $5 in EX, beq $5,$5 taken
      idle_inputs();
      id_is_branch = 1; id_rs = 5; id_rt = 5; branch_taken = 1;
      id_ex_rd = 5; id_ex_regwrite = 1; id_ex_memread = 0;
      cyc();
      chk("alu_no_bub", 32'(s_bub), 0);
      chk("alu_flush", 32'(s_fl), 1);

      // load_ex then mem_stall freeze for 3 cycles
      do_reset();
      id_is_branch = 1; id_rs = 3; id_rt = 4;
      id_ex_rd = 4; id_ex_regwrite = 1; id_ex_memread = 1;
      cyc();
      mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("frz_pc", 32'(s_pc), 0);
         chk("frz_bub", 32'(s_bub), 0);
         chk("frz_cnt", 32'(s_sc), 1);
      end
      mem_stall = 0;
      cyc();
      chk("frz_rem_bub", 32'(s_bub), 1);
      idle_inputs();
      cyc();
      chk("frz_run_pc", 32'(s_pc), 1);
      chk("frz_stall_cnt", 32'(s_sc), 2);

      // reset in the STALL cycle
      do_reset();
      id_is_branch = 1; id_rs = 9; id_rt = 2;
      id_ex_rd = 9; id_ex_regwrite = 1; id_ex_memread = 1;
      cyc();
      rst_n = 0;
      cyc();
      chk("rst_in_stall_pc", 32'(s_pc), 1);
      rst_n = 1;
      idle_inputs();
      cyc();
      chk("rst_after_stalling", 32'(s_stalling), 0);
      chk("rst_after_cnt", 32'(s_sc), 0);

      // saturation of stall_cycles
      do_reset();
      id_is_branch = 1; id_rs = 8; id_rt = 1;
      ex_mem_rd = 8; ex_mem_regwrite = 1; ex_mem_memread = 1;
      for (int i = 0; i < 20; i++) cyc();
      chk("sat_stall_cnt", 32'(stall_cycles), CMAX);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_n           = ($urandom_range(0, 99) >= 2);
         mem_stall       = ($urandom_range(0, 99) < 10);
         id_is_branch    = ($urandom_range(0, 99) < 60);
         branch_taken    = 1'($urandom);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         id_ex_rd        = 5'($urandom_range(0, 3));
         ex_mem_rd       = 5'($urandom_range(0, 3));
         id_ex_regwrite  = ($urandom_range(0, 99) < 60);
         ex_mem_regwrite = ($urandom_range(0, 99) < 60);
         id_ex_memread   = 1'($urandom);
         ex_mem_memread  = 1'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
